// File: rtl/io_stream_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : io_stream_buffer_if
// Brief    : Host-to-fabric stream handshake bundle for io_stream_buffer.
// Revision : 1.0
// ============================================================================
interface io_stream_buffer_if #(
    parameter int SIZE = 32
);
    logic [SIZE-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] out0;
    logic            out_valid;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out0,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out0,
        output out_valid
    );
endinterface
`default_nettype wire

// File: rtl/io_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : io_stream_buffer
// Brief    : 4-entry stream FIFO that issues one word per configurable
//            interval toward a fabric IO cell; serially configured.
// Revision : 1.0
// ============================================================================
module io_stream_buffer #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                config_clk,
    input  logic                config_reset,
    input  logic                config_in,
    output logic                config_out,
    io_stream_buffer_if.slave   bus,
    output logic                underflow,
    output logic [2:0]          level
);

    // ------------------------------------------------------------------
    // Serial configuration register (own clock and reset domain)
    // ------------------------------------------------------------------
    logic [3:0] cfg_q;

    always_ff @(posedge config_clk or posedge config_reset) begin
        if (config_reset) begin
            cfg_q <= 4'd0;
        end else begin
            cfg_q <= {config_in, cfg_q[3:1]};
        end
    end

    logic       w_enable;
    logic [2:0] w_ii_m1;

    assign w_enable   = cfg_q[0];
    assign w_ii_m1    = cfg_q[3:1];
    assign config_out = cfg_q[0];

    // ------------------------------------------------------------------
    // Data-path state
    // ------------------------------------------------------------------
    logic [SIZE-1:0] mem_q [DEPTH];
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0]      rd_ptr_q, rd_ptr_d;
    logic [2:0]      level_q,  level_d;
    logic [2:0]      cnt_q,    cnt_d;
    logic [SIZE-1:0] out0_q,   out0_d;
    logic            out_valid_q, out_valid_d;
    logic            underflow_q, underflow_d;

    logic w_in_ready;
    logic w_push;
    logic w_slot;
    logic w_pop;

    // Ready looks only at current occupancy so a full FIFO never accepts,
    // even when the same cycle pops.
    assign w_in_ready = (level_q < 3'(DEPTH));
    assign w_push     = bus.in_valid & w_in_ready;
    assign w_slot     = w_enable & (cnt_q >= w_ii_m1);
    assign w_pop      = w_slot & (level_q != 3'd0);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q + 3'(w_push) - 3'(w_pop);
        cnt_d       = 3'd0;
        out0_d      = out0_q;
        out_valid_d = w_pop;
        underflow_d = underflow_q | (w_slot & (level_q == 3'd0));

        if (w_enable && !w_slot) begin
            cnt_d = cnt_q + 3'd1;
        end
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
            out0_d   = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            level_q     <= 3'd0;
            cnt_q       <= 3'd0;
            out0_q      <= '0;
            out_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            out0_q      <= out0_d;
            out_valid_q <= out_valid_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: pointers and level gate every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out0      = out0_q;
    assign bus.out_valid = out_valid_q;
    assign underflow     = underflow_q;
    assign level         = level_q;

endmodule
`default_nettype wire
